shift_controller_32bit: RTL and testbench
=========================================

SHIFT_CONTROLLER_32BIT -- requirements
Module: shift_controller_32bit

Interface
REQ-001 The block SHALL use one clock, `clk`, and one reset, `rst`; `rst` SHALL be asynchronous and active-high.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock.
REQ-003 Port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-004 Port `in_valid`, input, 1 bit: a request is present on `op`/`X`/`Y`.
REQ-005 Port `in_ready`, output, 1 bit: the controller can accept a request.
REQ-006 Port `op`, input, 2 bits: operation select; 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR.
REQ-007 Port `X`, input, 32 bits: operand to be shifted.
REQ-008 Port `Y`, input, 32 bits: shift amount, unsigned.
REQ-009 Port `out_valid`, output, 1 bit: `Z` holds a completed result.
REQ-010 Port `out_ready`, input, 1 bit: the consumer accepts the result.
REQ-011 Port `Z`, output, 32 bits: result.
REQ-012 Port `busy`, output, 1 bit: high in the SHIFT and DONE states.

Function
REQ-013 The controller SHALL implement states IDLE, SHIFT and DONE; `in_ready` SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge where IDLE and `in_valid`=1; `op`, `X` and the effective amount N SHALL be latched at that edge.
REQ-015 For SLL, SRL and SRA: N = 32 when Y > 31, otherwise Y[4:0]; for ROR: N = Y[4:0].
REQ-016 If N = 0 at accept, the next state SHALL be DONE with Z = X; otherwise the next state SHALL be SHIFT.
REQ-017 In SHIFT, each edge SHALL perform one step of the selected operation on the working register and decrement the remaining count by the step size.
REQ-018 Step fill rules: SLL fills the LSB with 0; SRL fills the MSB with 0; SRA fills the MSB with a copy of the current bit 31; ROR moves the LSB into the MSB.
REQ-019 The edge whose step brings the remaining count to 0 SHALL move the state to DONE.
REQ-020 The completed results SHALL be: SLL with N=32 gives 0; SRL with N=32 gives 0; SRA with N=32 gives 32 copies of X[31].
REQ-021 In DONE, `out_valid`=1 and Z SHALL be held stable until an edge with `out_ready`=1, which SHALL return the state to IDLE.
REQ-022 A new request SHALL NOT be accepted on the same edge that leaves DONE.
REQ-023 `in_valid` SHALL be ignored outside IDLE, and `out_ready` SHALL be ignored outside DONE.
REQ-024 Latency, counted in edges from accept to `out_valid`=1, SHALL be 1 + (number of steps).
REQ-025 Z SHALL be 0 until the first result is produced; in IDLE, Z SHALL keep the last result.

Reset
REQ-026 While `rst`=1, the state SHALL be IDLE with `out_valid`=0, `busy`=0, `in_ready`=1 and Z=0, and the remaining count and working register SHALL be 0.
REQ-027 Asserting `rst` during SHIFT or DONE SHALL abort the operation immediately, and the aborted result SHALL never appear on Z.

Configuration
REQ-028 With macro `SHIFT_CTRL_FAST_EN` defined, each step SHALL be 8 positions while the remaining count is ≥ 8 and 1 position otherwise, giving steps = floor(N/8) + N mod 8.
REQ-029 With `SHIFT_CTRL_FAST_EN` undefined, each step SHALL be 1 position, giving steps = N; results SHALL be identical in both builds.

Verification
REQ-030 SRA, X=0x7fffffff, Y=0x10 SHALL give Z=0x00007fff with latency 17 edges, or 3 edges with `SHIFT_CTRL_FAST_EN`.
REQ-031 SRA, X=0xaaaaaaaa, Y=1 SHALL give Z=0xd5555555 with latency 2; SRL with the same operands SHALL give Z=0x55555555.
REQ-032 SRA, X=0x80000000, Y=0xffffffff SHALL give Z=0xffffffff; SRL and SLL with X=0xffffffff, Y=0xff SHALL give Z=0x00000000, with latency 33, or 5 with `SHIFT_CTRL_FAST_EN`.
REQ-033 ROR, X=0x00000001, Y=0x21 SHALL give Z=0x80000000; any op with Y=0 SHALL give Z=X with latency 1.
REQ-034 With `out_ready`=0 for 5 cycles in DONE and `in_valid` pulsed, Z SHALL remain stable and `in_ready`=0, and no second request SHALL be accepted.
REQ-035 `rst` pulsed mid-SHIFT (SLL, Y=20, after 5 edges) SHALL give `out_valid`=0, Z=0 and `in_ready`=1 immediately, and the next request SHALL complete correctly.

Source files
------------

// File: rtl/shift_controller_32bit_if.sv
// Request/result handshake bundle for shift_controller_32bit.
// master = requester/consumer side, slave = the controller.
interface shift_controller_32bit_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] X;
    logic [31:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Z;
    logic        busy;

    modport master (
        output in_valid, op, X, Y, out_ready,
        input  in_ready, out_valid, Z, busy
    );

    modport slave (
        input  in_valid, op, X, Y, out_ready,
        output in_ready, out_valid, Z, busy
    );
endinterface

// File: rtl/shift_controller_32bit.sv
// Iterative 32-bit shifter (SLL/SRL/SRA/ROR) behind a valid/ready handshake.
// Optional macro SHIFT_CTRL_FAST_EN: 8-position steps while >= 8 positions remain.
module shift_controller_32bit (
    input  logic                     clk,
    input  logic                     rst,
    shift_controller_32bit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;

    state_e      r_state;
    state_e      w_next_state;
    op_e         r_op;
    logic [31:0] r_work;
    logic [31:0] r_z;
    logic [5:0]  r_cnt;
    logic [5:0]  w_n;
    logic [5:0]  w_step_size;
    logic [31:0] w_step_work;

    // Linear shifts saturate at 32 positions; rotate only cares about Y mod 32.
    assign w_n = ((bus.op != OP_ROR) && (|bus.Y[31:5])) ? 6'd32 : {1'b0, bus.Y[4:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_step_size = 6'd1;
        w_step_work = r_work;
        case (r_op)
            OP_SLL:  w_step_work = {r_work[30:0], 1'b0};
            OP_SRL:  w_step_work = {1'b0, r_work[31:1]};
            OP_SRA:  w_step_work = {r_work[31], r_work[31:1]};
            default: w_step_work = {r_work[0], r_work[31:1]};
        endcase
`ifdef SHIFT_CTRL_FAST_EN
        if (r_cnt >= 6'd8) begin
            w_step_size = 6'd8;
            case (r_op)
                OP_SLL:  w_step_work = {r_work[23:0], 8'h00};
                OP_SRL:  w_step_work = {8'h00, r_work[31:8]};
                OP_SRA:  w_step_work = {{8{r_work[31]}}, r_work[31:8]};
                default: w_step_work = {r_work[7:0], r_work[31:8]};
            endcase
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.Z         = r_z;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) w_next_state = (w_n == 6'd0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == w_step_size) w_next_state = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // r_z only loads on entry to DONE, so a reset mid-operation never exposes a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_SLL;
            r_work <= 32'h0;
            r_cnt  <= 6'd0;
            r_z    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op   <= op_e'(bus.op);
                        r_work <= bus.X;
                        r_cnt  <= w_n;
                        if (w_n == 6'd0) r_z <= bus.X;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_step_work;
                    r_cnt  <= r_cnt - w_step_size;
                    if (r_cnt == w_step_size) r_z <= w_step_work;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_controller_32bit.sv
// Scoreboard bench for shift_controller_32bit: expected result/latency queued at drive,
// popped when out_valid rises. Build with +define+SHIFT_CTRL_FAST_EN to match the fast RTL.
module tb_shift_controller_32bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_controller_32bit_if bus ();

    shift_controller_32bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] z;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int eff_n(input logic [1:0] op, input logic [31:0] y);
        if (op != 2'b11 && y > 32'd31) return 32;
        return int'(y[4:0]);
    endfunction

    function automatic logic [31:0] model_z(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        int n;
        n = eff_n(op, y);
        case (op)
            2'b00:   return (n == 32) ? 32'h0 : (x << n);
            2'b01:   return (n == 32) ? 32'h0 : (x >> n);
            2'b10:   return (n == 32) ? {32{x[31]}} : 32'($signed(x) >>> n);
            default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] y);
        int n;
        n = eff_n(op, y);
`ifdef SHIFT_CTRL_FAST_EN
        return 1 + n / 8 + n % 8;
`else
        return 1 + n;
`endif
    endfunction

    // Drive one request, wait for the result, optionally stall in DONE with in_valid pulsed.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.X        = x;
        bus.Y        = y;
        sb.push_back('{tag, model_z(op, x, y), model_lat(op, y)});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({e.tag, " Z"}, bus.Z, e.z);
        check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.X        = ~x;
            bus.Y        = 32'd0;
            @(posedge clk); #1;
            check({e.tag, " hold Z"}, bus.Z, e.z);
            check({e.tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            check({e.tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
        end
        // Release with in_valid still high: the leaving edge must not accept it.
        @(negedge clk);
        bus.out_ready = 1'b1;
        if (hold > 0) bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({e.tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
        check({e.tag, " idle busy"}, 32'(bus.busy), 32'd0);
        check({e.tag, " idle Z kept"}, bus.Z, e.z);
        if (hold > 0) begin
            repeat (2) @(posedge clk);
            #1;
            check({e.tag, " no 2nd accept"}, 32'({bus.out_valid, bus.busy}), 32'd0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.X         = 32'h0;
        bus.Y         = 32'h0;
        #2;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst Z", bus.Z, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sra_16",      2'b10, 32'h7fffffff, 32'h10, 0);
        run_op("sra_1",       2'b10, 32'haaaaaaaa, 32'h1, 0);
        run_op("srl_1",       2'b01, 32'haaaaaaaa, 32'h1, 0);
        run_op("sra_big",     2'b10, 32'h80000000, 32'hffffffff, 0);
        run_op("srl_big",     2'b01, 32'hffffffff, 32'hff, 0);
        run_op("sll_big",     2'b00, 32'hffffffff, 32'hff, 0);
        run_op("ror_33",      2'b11, 32'h00000001, 32'h21, 0);
        run_op("ror_8",       2'b11, 32'h12345678, 32'h8, 0);
        run_op("sll_31",      2'b00, 32'h00000001, 32'd31, 0);
        run_op("sra_32",      2'b10, 32'h7fffffff, 32'd32, 0);
        for (int k = 0; k < 4; k++)
            run_op($sformatf("zero_op%0d", k), 2'(k), 32'hc0ffee11, 32'h0, 0);
        run_op("hold",        2'b00, 32'h0000f00d, 32'd3, 5);
        for (int k = 0; k < 8; k++)
            run_op($sformatf("rand%0d", k), 2'($urandom_range(0, 3)), $urandom(),
                   32'($urandom_range(0, 40)), 0);

        // Asynchronous reset mid-SHIFT: SLL Y=20, five edges in.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.X        = 32'h0000abcd;
        bus.Y        = 32'd20;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort Z", bus.Z, 32'h0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_abort",  2'b00, 32'h0000abcd, 32'd20, 0);

        check("sb empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
